fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage and its main decoder; supplies {pc, instr} pairs to decode.
- Owns the PC, issues in-order requests to instruction memory and buffers returned words in a small FIFO.
- Supports redirects from jump resolution and halts issue on the pause signal raised by decode.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus bundle: imem request/response, decode handshake, redirect and halt
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;
    logic            halted;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, halted,
        input  imem_ready, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, halted,
        output imem_ready, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, in-order imem requests, {pc, instr} FIFO toward decode
// Optional macro FETCH_PERF_COUNTERS_EN adds perf_fetched / perf_stall counters.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      bus
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {RUN, HALT_DRAIN, HALTED} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, tag_pc;
    logic            inflight, squash;
    logic [31:0]     buf_instr [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc    [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            accept, push, pop, idle;

    assign idle          = !inflight && (count == '0);
    // Credits come from registered state only, so a same-cycle pop never frees a slot early.
    assign bus.imem_req  = !reset && !bus.halt && !bus.redirect_valid &&
                           ((count + CW'(inflight)) < CW'(BUF_DEPTH));
    assign bus.imem_addr = {pc[XLEN-1:2], 2'b00};
    assign accept        = bus.imem_req && bus.imem_ready;
    assign push          = bus.imem_rvalid && inflight && !squash && !bus.redirect_valid;
    assign bus.id_valid  = (count != '0);
    assign pop           = bus.id_valid && bus.id_ready;
    assign bus.id_instr  = bus.id_valid ? buf_instr[rd_ptr] : '0;
    assign bus.id_pc     = bus.id_valid ? buf_pc[rd_ptr] : '0;
    assign bus.halted    = (state == HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= {RESET_PC[XLEN-1:2], 2'b00};
            tag_pc   <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                inflight <= 1'b1;
                tag_pc   <= pc;
            end else if (bus.imem_rvalid) begin
                inflight <= 1'b0;
            end
            if (bus.redirect_valid) begin
                pc     <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                // A response arriving in the redirect cycle is already dropped; only a later one needs squash.
                squash <= inflight && !bus.imem_rvalid;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (accept)
                    pc <= pc + XLEN'(4);
                if (bus.imem_rvalid && inflight)
                    squash <= 1'b0;
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_instr[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]    <= tag_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(push && !pop && count == CW'(BUF_DEPTH)));
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:        if (bus.halt) state_next = HALT_DRAIN;
            HALT_DRAIN: if (!bus.halt) state_next = RUN;
                        else if (idle) state_next = HALTED;
            HALTED:     if (!bus.halt) state_next = RUN;
            default:    state_next = RUN;
        endcase
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + 32'd1;
            if (bus.id_ready && !bus.id_valid)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_stall;
    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .perf_fetched(perf_fetched), .perf_stall(perf_stall)
    );
`else
    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    // Memory: one-cycle latency, returns ~addr; stray forces a response with no request.
    logic        acc_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    logic        stray = 1'b0;
    always @(negedge clk) begin
        acc_prev  = bus.imem_req && bus.imem_ready;
        addr_prev = bus.imem_addr;
    end
    always @(posedge clk) begin
        #1;
        bus.imem_rvalid = acc_prev || stray;
        bus.imem_rdata  = stray ? 32'hDEAD_BEEF : ~addr_prev;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        bus.imem_ready = 1'b0; bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.imem_ready = 1'b1; bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        reset = 1'b1;
        cyc();
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b exp 0", bus.id_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", bus.id_pc); end
        checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr got %h exp 0", bus.id_instr); end
    endtask

    task automatic test_sequential();
        logic        exp_req [7] = '{1, 1, 0, 1, 1, 0, 1};
        logic [31:0] exp_addr[7] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10};
        logic        exp_vld [7] = '{0, 0, 1, 1, 0, 1, 1};
        logic [31:0] exp_pc  [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'hC};
        do_reset();
        bus.imem_ready = 1'b1; bus.id_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            @(negedge clk);
            checks++; if (bus.imem_req !== exp_req[i]) begin errors++; $display("FAIL seq_req[%0d] got %b exp %b", i, bus.imem_req, exp_req[i]); end
            if (exp_req[i]) begin
                checks++; if (bus.imem_addr !== exp_addr[i]) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, bus.imem_addr, exp_addr[i]); end
            end
            checks++; if (bus.id_valid !== exp_vld[i]) begin errors++; $display("FAIL seq_id_valid[%0d] got %b exp %b", i, bus.id_valid, exp_vld[i]); end
            checks++; if (bus.id_pc !== exp_pc[i]) begin errors++; $display("FAIL seq_id_pc[%0d] got %h exp %h", i, bus.id_pc, exp_pc[i]); end
            checks++; if (bus.id_instr !== (exp_vld[i] ? ~exp_pc[i] : 32'h0)) begin errors++; $display("FAIL seq_id_instr[%0d] got %h exp %h", i, bus.id_instr, exp_vld[i] ? ~exp_pc[i] : 32'h0); end
        end
    endtask

    task automatic test_backpressure();
        logic        exp_req [8] = '{1, 1, 0, 0, 0, 0, 1, 1};
        logic [31:0] exp_addr[8] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC};
        logic        exp_vld [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
        logic [31:0] exp_pc  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
        do_reset();
        bus.imem_ready = 1'b1; bus.id_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            bus.id_ready = (i >= 5);
            @(negedge clk);
            checks++; if (bus.imem_req !== exp_req[i]) begin errors++; $display("FAIL bp_req[%0d] got %b exp %b", i, bus.imem_req, exp_req[i]); end
            if (exp_req[i]) begin
                checks++; if (bus.imem_addr !== exp_addr[i]) begin errors++; $display("FAIL bp_addr[%0d] got %h exp %h", i, bus.imem_addr, exp_addr[i]); end
            end
            checks++; if (bus.id_valid !== exp_vld[i]) begin errors++; $display("FAIL bp_id_valid[%0d] got %b exp %b", i, bus.id_valid, exp_vld[i]); end
            checks++; if (bus.id_pc !== exp_pc[i]) begin errors++; $display("FAIL bp_id_pc[%0d] got %h exp %h", i, bus.id_pc, exp_pc[i]); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.imem_ready = 1'b1; bus.id_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rd_first_addr got %h exp 0", bus.imem_addr); end
        cyc();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_in_redirect got %b exp 0", bus.imem_req); end
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rd_flushed got %b exp 0", bus.id_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rd_new_addr got req %b addr %h exp req 1 addr 100", bus.imem_req, bus.imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped got %b exp 0", bus.id_valid); end
        checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL rd_addr2 got %h exp 104", bus.imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100) begin errors++; $display("FAIL rd_first_pc got valid %b pc %h exp valid 1 pc 100", bus.id_valid, bus.id_pc); end
        checks++; if (bus.id_instr !== ~32'h100) begin errors++; $display("FAIL rd_first_instr got %h exp %h", bus.id_instr, ~32'h100); end
    endtask

    task automatic test_halt();
        logic exp_halted[7] = '{0, 0, 0, 1, 1, 1, 0};
        logic exp_req   [7] = '{0, 0, 0, 0, 0, 1, 1};
        do_reset();
        bus.imem_ready = 1'b1; bus.id_ready = 1'b0;
        cyc();
        cyc();
        bus.halt = 1'b1; bus.id_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            if (i == 5) bus.halt = 1'b0;
            @(negedge clk);
            checks++; if (bus.halted !== exp_halted[i]) begin errors++; $display("FAIL halt_halted[%0d] got %b exp %b", i, bus.halted, exp_halted[i]); end
            checks++; if (bus.imem_req !== exp_req[i]) begin errors++; $display("FAIL halt_req[%0d] got %b exp %b", i, bus.imem_req, exp_req[i]); end
            if (i == 0) begin
                checks++; if (bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) begin errors++; $display("FAIL halt_drain0 got valid %b pc %h exp valid 1 pc 0", bus.id_valid, bus.id_pc); end
            end
            if (i == 1) begin
                checks++; if (bus.id_pc !== 32'h4 || bus.id_valid !== 1'b1) begin errors++; $display("FAIL halt_drain1 got valid %b pc %h exp valid 1 pc 4", bus.id_valid, bus.id_pc); end
            end
            if (i == 5) begin
                checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL halt_resume_addr got %h exp 8", bus.imem_addr); end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_req_redirect got %b exp 0", bus.imem_req); end
        cyc();
        bus.redirect_valid = 1'b0; bus.imem_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_addr got %h exp fffffffc", bus.imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero_addr got req %b addr %h exp req 1 addr 0", bus.imem_req, bus.imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_instr !== 32'h3) begin errors++; $display("FAIL wrap_head got pc %h instr %h exp pc fffffffc instr 3", bus.id_pc, bus.id_instr); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.imem_ready = 1'b1; bus.id_ready = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_full got valid %b req %b exp valid 1 req 0", bus.id_valid, bus.imem_req); end
        cyc();
        reset = 1'b1; stray = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_in_reset got %b exp 0", bus.imem_req); end
        cyc();
        reset = 1'b0; stray = 1'b0;
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed got %b exp 0", bus.id_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got req %b addr %h exp req 1 addr 0", bus.imem_req, bus.imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL mid_stray_ignored got %b exp 0", bus.id_valid); end
        cyc();
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_instr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_first got valid %b pc %h instr %h exp 1 0 ffffffff", bus.id_valid, bus.id_pc, bus.id_instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
